// File: rtl/err_mon_pkg.sv
// Shared definitions for the error-convergence monitor: FSM state codes and
// the saturation constant of the U(16,16) power format.
package err_mon_pkg;

  // Power values are U(16,16): unsigned, 16 fraction bits, full scale just below 1.0.
  localparam logic [15:0] POW_SAT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_ADAPT = 2'd0,
    ST_CONV  = 2'd1,
    ST_FAIL  = 2'd2
  } state_t;

endpackage

// File: rtl/err_power_est.sv
// Error power estimator: saturating squarer followed by a leaky integrator
// with time constant 2^ALPHA_SHIFT samples; emits a one-cycle valid per update.
module err_power_est
  import err_mon_pkg::*;
#(
  parameter int NB_DATA     = 16,
  parameter int ALPHA_SHIFT = 6
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic signed [NB_DATA-1:0] i_err,
  output logic        [NB_DATA-1:0] o_pwr,
  output logic                      o_pwr_valid
);

  localparam int NB_ACC  = NB_DATA + ALPHA_SHIFT;
  localparam int NB_PROD = 2 * NB_DATA;

  // Only the most negative input squares to exactly 1.0, which U(16,16) cannot hold.
  function automatic logic [NB_DATA-1:0] sat_square(input logic signed [NB_DATA-1:0] x);
    logic signed [NB_PROD-1:0] p;
    p = NB_PROD'(x) * NB_PROD'(x);
    if (p[NB_PROD-2]) begin
      return NB_DATA'(POW_SAT);
    end
    return NB_DATA'(p >> (NB_DATA - 2));
  endfunction

  logic [NB_DATA-1:0] w_sq_p0;
  logic [NB_DATA-1:0] r_sq_p1;
  logic               r_vld_p1;
  logic [NB_ACC-1:0]  r_acc_p2;
  logic [NB_ACC-1:0]  w_acc_nxt;
  logic               r_vld_p2;

  assign w_sq_p0 = sat_square(i_err);

  // p1 -> p2: acc - acc/2^ALPHA + sq stays below 2^NB_ACC, so no wrap is possible.
  assign w_acc_nxt = r_acc_p2 - (r_acc_p2 >> ALPHA_SHIFT) + NB_ACC'(r_sq_p1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_sq_p1  <= '0;
      r_acc_p2 <= '0;
    end else begin
      r_vld_p1 <= i_valid;
      r_vld_p2 <= r_vld_p1;
      if (i_valid) begin
        r_sq_p1 <= w_sq_p0;
      end
      if (r_vld_p1) begin
        r_acc_p2 <= w_acc_nxt;
      end
    end
  end

  assign o_pwr       = r_acc_p2[NB_ACC-1:ALPHA_SHIFT];
  assign o_pwr_valid = r_vld_p2;

endmodule

// File: rtl/err_convergence_monitor.sv
// Convergence monitor for the adaptive canceller: tracks error power and
// declares the LMS loop adapting, converged or failed, recording convergence time.
module err_convergence_monitor
  import err_mon_pkg::*;
#(
  parameter int NB_DATA     = 16,
  parameter int ALPHA_SHIFT = 6,
  parameter int HOLD        = 256,
  parameter int TIMEOUT     = 60000,
  parameter int NB_TIME     = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic signed [NB_DATA-1:0] i_err,
  input  logic                      i_clr,
  input  logic        [NB_DATA-1:0] i_thr_conv,
  input  logic        [NB_DATA-1:0] i_thr_div,
  output logic        [NB_DATA-1:0] o_pwr,
  output logic        [1:0]         o_state,
  output logic                      o_converged,
  output logic                      o_fail,
  output logic        [NB_TIME-1:0] o_conv_time
);

  localparam int                   NB_RUN    = $clog2(HOLD + 1);
  localparam logic [NB_RUN-1:0]    HOLD_R    = NB_RUN'(HOLD);
  localparam logic [NB_TIME-1:0]   TIMEOUT_R = NB_TIME'(TIMEOUT);

  logic [NB_DATA-1:0] w_pwr;
  logic               w_pwr_vld;

  err_power_est #(
    .NB_DATA     (NB_DATA),
    .ALPHA_SHIFT (ALPHA_SHIFT)
  ) u_pwr (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_err       (i_err),
    .o_pwr       (w_pwr),
    .o_pwr_valid (w_pwr_vld)
  );

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NB_RUN-1:0]  r_run;
  logic [NB_RUN-1:0]  w_run_nxt;
  logic [NB_RUN-1:0]  w_run_q;
  logic [NB_RUN-1:0]  w_run_sat;
  logic [NB_TIME-1:0] r_t;
  logic [NB_TIME-1:0] w_t_nxt;
  logic [NB_TIME-1:0] w_t_inc;
  logic [NB_TIME-1:0] r_ct;
  logic [NB_TIME-1:0] w_ct_nxt;
  logic               w_qual;
  logic               r_conv;
  logic               r_fail;

  assign w_t_inc   = r_t + NB_TIME'(1);
  assign w_run_sat = (r_run == HOLD_R) ? HOLD_R : r_run + NB_RUN'(1);

  // p2 -> p3: one evaluation per power update; clear overrides any transition.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_t_nxt     = r_t;
    w_ct_nxt    = r_ct;
    w_qual      = 1'b0;
    w_run_q     = '0;

    if (i_clr) begin
      w_state_nxt = ST_ADAPT;
      w_run_nxt   = '0;
      w_t_nxt     = '0;
      w_ct_nxt    = '0;
    end else if (w_pwr_vld) begin
      case (r_state)
        ST_ADAPT: w_qual = (w_pwr < i_thr_conv);
        ST_CONV:  w_qual = (w_pwr >= i_thr_div);
        default:  w_qual = 1'b0;
      endcase
      w_run_q = w_qual ? w_run_sat : '0;

      case (r_state)
        ST_ADAPT: begin
          w_t_nxt = w_t_inc;
          if (w_run_q == HOLD_R) begin
            w_state_nxt = ST_CONV;
            w_ct_nxt    = w_t_inc;
            w_run_nxt   = '0;
          end else if (w_t_inc == TIMEOUT_R) begin
            w_state_nxt = ST_FAIL;
            w_run_nxt   = '0;
          end else begin
            w_run_nxt   = w_run_q;
          end
        end
        ST_CONV: begin
          if (w_run_q == HOLD_R) begin
            w_state_nxt = ST_ADAPT;
            w_t_nxt     = '0;
            w_run_nxt   = '0;
          end else begin
            w_run_nxt   = w_run_q;
          end
        end
        default: begin
          w_run_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_ADAPT;
      r_run   <= '0;
      r_t     <= '0;
      r_ct    <= '0;
      r_conv  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= w_run_nxt;
      r_t     <= w_t_nxt;
      r_ct    <= w_ct_nxt;
      r_conv  <= (w_state_nxt == ST_CONV);
      r_fail  <= (w_state_nxt == ST_FAIL);
    end
  end

  assign o_pwr       = w_pwr;
  assign o_state     = r_state;
  assign o_converged = r_conv;
  assign o_fail      = r_fail;
  assign o_conv_time = r_ct;

endmodule

// File: tb/tb_err_convergence_monitor.sv
// Bench for err_convergence_monitor: a power/FSM reference model fills a
// scoreboard as samples are driven; results are compared as the DUT emits them.
module tb_err_convergence_monitor;

  localparam int S_ADAPT = 0;
  localparam int S_CONV  = 1;
  localparam int S_FAIL  = 2;
  localparam int M_HOLD  = 256;
  localparam int M_TO    = 60000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic               vm, clrm;
  logic signed [15:0] em;
  logic        [15:0] tcm, tdm;
  logic        [15:0] pwr_m, ct_m;
  logic        [1:0]  st_m;
  logic               conv_m, fail_m;

  logic               vt, clrt;
  logic signed [15:0] et;
  logic        [15:0] tct, tdt;
  logic        [15:0] pwr_t, ct_t;
  logic        [1:0]  st_t;
  logic               conv_t, fail_t;

  err_convergence_monitor #(
    .NB_DATA(16), .ALPHA_SHIFT(6), .HOLD(256), .TIMEOUT(60000), .NB_TIME(16)
  ) dut_m (
    .i_clk(clk), .i_rst(rst), .i_valid(vm), .i_err(em), .i_clr(clrm),
    .i_thr_conv(tcm), .i_thr_div(tdm), .o_pwr(pwr_m), .o_state(st_m),
    .o_converged(conv_m), .o_fail(fail_m), .o_conv_time(ct_m)
  );

  // Short HOLD/TIMEOUT so that timeout and the converge/timeout tie are reachable.
  err_convergence_monitor #(
    .NB_DATA(16), .ALPHA_SHIFT(6), .HOLD(100), .TIMEOUT(100), .NB_TIME(16)
  ) dut_t (
    .i_clk(clk), .i_rst(rst), .i_valid(vt), .i_err(et), .i_clr(clrt),
    .i_thr_conv(tct), .i_thr_div(tdt), .o_pwr(pwr_t), .o_state(st_t),
    .o_converged(conv_t), .o_fail(fail_t), .o_conv_time(ct_t)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int m_acc, m_st, m_run, m_t, m_ct;
  int acc_t;
  int q_pwr[$];
  int q_st[$];
  int q_ct[$];
  bit p1, p2, p3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_empty(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s: DUT produced a result, scoreboard held no expectation", tag);
  endtask

  function automatic int sq_of(input logic signed [15:0] e);
    int v;
    v = int'(e);
    if (v == -32768) return 65535;
    return (v * v) / 16384;
  endfunction

  task automatic mdl_clear();
    m_st = S_ADAPT; m_run = 0; m_t = 0; m_ct = 0;
  endtask

  task automatic mdl_sample(input logic signed [15:0] e);
    int pw;
    bit q;
    m_acc = m_acc - (m_acc / 64) + sq_of(e);
    pw    = m_acc / 64;
    q_pwr.push_back(pw);
    if (m_st == S_ADAPT)     q = (pw < int'(tcm));
    else if (m_st == S_CONV) q = (pw >= int'(tdm));
    else                     q = 1'b0;
    m_run = q ? ((m_run < M_HOLD) ? m_run + 1 : M_HOLD) : 0;
    if (m_st == S_ADAPT) begin
      m_t++;
      if (m_run == M_HOLD) begin
        m_st = S_CONV; m_ct = m_t; m_run = 0;
      end else if (m_t == M_TO) begin
        m_st = S_FAIL; m_run = 0;
      end
    end else if (m_st == S_CONV) begin
      if (m_run == M_HOLD) begin
        m_st = S_ADAPT; m_t = 0; m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    q_st.push_back(m_st);
    q_ct.push_back(m_ct);
  endtask

  // One clock on the main DUT; power is checked one edge after acceptance+1, FSM one edge later.
  task automatic step(input bit v, input logic signed [15:0] e);
    vm = v;
    em = e;
    if (v) mdl_sample(e);
    @(posedge clk);
    p3 = p2; p2 = p1; p1 = v;
    #1;
    if (p2) begin
      if (q_pwr.size() == 0) sb_empty("sb_pwr");
      else begin
        int ep;
        ep = q_pwr.pop_front();
        chk("sb_pwr", 32'(pwr_m), ep);
      end
    end
    if (p3) begin
      if (q_st.size() == 0) sb_empty("sb_state");
      else begin
        int es, ec;
        es = q_st.pop_front();
        ec = q_ct.pop_front();
        chk("sb_state", 32'(st_m), es);
        chk("sb_converged", 32'(conv_m), 32'(es == S_CONV));
        chk("sb_fail", 32'(fail_m), 32'(es == S_FAIL));
        chk("sb_conv_time", 32'(ct_m), ec);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'sh0000);
  endtask

  task automatic clr_m_pulse(input bit v, input logic signed [15:0] e);
    clrm = 1'b1;
    mdl_clear();
    step(v, e);
    clrm = 1'b0;
  endtask

  task automatic step_t(input bit v, input logic signed [15:0] e);
    vt = v;
    et = e;
    if (v) acc_t = acc_t - (acc_t / 64) + sq_of(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_t(input int n);
    repeat (n) step_t(1'b0, 16'sh0000);
  endtask

  task automatic reset_all();
    rst = 1'b1; vm = 1'b0; vt = 1'b0; clrm = 1'b0; clrt = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_acc = 0; acc_t = 0;
    mdl_clear();
    q_pwr.delete(); q_st.delete(); q_ct.delete();
    p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; vm = 1'b0; em = '0; clrm = 1'b0; tcm = 16'h0100; tdm = 16'h0400;
    vt  = 1'b0; et = '0; clrt = 1'b0; tct = 16'h0100; tdt = 16'h0400;
    repeat (2) @(posedge clk);
    reset_all();

    chk("rst_pwr", 32'(pwr_m), 0);
    chk("rst_state", 32'(st_m), S_ADAPT);
    chk("rst_converged", 32'(conv_m), 0);
    chk("rst_fail", 32'(fail_m), 0);
    chk("rst_conv_time", 32'(ct_m), 0);
    chk("rst_t_state", 32'(st_t), S_ADAPT);

    // Timeout: 100 evaluations above thr_conv with TIMEOUT = 100
    repeat (99) step_t(1'b1, 16'sh4000);
    idle_t(3);
    chk("to_before_fail", 32'(fail_t), 0);
    chk("to_before_state", 32'(st_t), S_ADAPT);
    step_t(1'b1, 16'sh4000);
    idle_t(3);
    chk("to_fail", 32'(fail_t), 1);
    chk("to_state", 32'(st_t), S_FAIL);
    chk("to_conv", 32'(conv_t), 0);
    repeat (400) step_t(1'b1, 16'sh0000);
    idle_t(3);
    chk("fail_sticky", 32'(fail_t), 1);
    chk("fail_sticky_state", 32'(st_t), S_FAIL);

    clrt = 1'b1;
    step_t(1'b0, 16'sh0000);
    clrt = 1'b0;
    chk("clr_state", 32'(st_t), S_ADAPT);
    chk("clr_fail", 32'(fail_t), 0);
    chk("clr_conv_time", 32'(ct_t), 0);
    chk("clr_pwr_kept", 32'(pwr_t), acc_t / 64);

    // Converge and timeout on the same (100th) evaluation
    repeat (99) step_t(1'b1, 16'sh0000);
    idle_t(3);
    chk("tie_before", 32'(st_t), S_ADAPT);
    step_t(1'b1, 16'sh0000);
    idle_t(3);
    chk("tie_state", 32'(st_t), S_CONV);
    chk("tie_converged", 32'(conv_t), 1);
    chk("tie_fail", 32'(fail_t), 0);
    chk("tie_conv_time", 32'(ct_t), 100);

    // Convergence at zero error
    repeat (255) step(1'b1, 16'sh0000);
    idle(3);
    chk("zero_not_yet", 32'(conv_m), 0);
    step(1'b1, 16'sh0000);
    chk("zero_conv_e0", 32'(conv_m), 0);
    idle(1);
    chk("zero_conv_e1", 32'(conv_m), 0);
    idle(1);
    chk("zero_conv_e2", 32'(conv_m), 1);
    chk("zero_conv_time", 32'(ct_m), 256);
    chk("zero_pwr", 32'(pwr_m), 0);

    // Hysteresis: power between the thresholds keeps CONV
    repeat (1000) step(1'b1, 16'sh0B50);
    idle(3);
    chk("hyst_state", 32'(st_m), S_CONV);
    chk("hyst_range", 32'(pwr_m >= 16'h0100 && pwr_m < 16'h0400), 1);

    // Large error: back to ADAPT after 256 evaluations above thr_div, then settle
    repeat (250) step(1'b1, 16'sh4000);
    idle(3);
    chk("div_still_conv", 32'(st_m), S_CONV);
    repeat (750) step(1'b1, 16'sh4000);
    idle(3);
    chk("div_state", 32'(st_m), S_ADAPT);
    chk("const_pwr", 32'(pwr_m), 32'h4000);

    // Saturated squarer
    repeat (800) step(1'b1, 16'sh8000);
    idle(3);
    chk("sat_pwr", 32'(pwr_m), 32'hFFFF);
    chk("sat_state", 32'(st_m), S_ADAPT);

    // Clear with a concurrent sample, then gapped input
    clr_m_pulse(1'b1, 16'sh0000);
    chk("clrm_state", 32'(st_m), S_ADAPT);
    chk("clrm_conv_time", 32'(ct_m), 0);
    chk("clrm_pwr_kept", 32'(pwr_m), 32'hFFFF);
    repeat (800) begin
      step(1'b1, 16'sh0000);
      step(1'b0, 16'sh0000);
    end
    idle(3);
    chk("gap_converged", 32'(conv_m), 1);
    chk("gap_conv_time", 32'(ct_m), m_ct);

    // Reset with a sample in flight
    clr_m_pulse(1'b0, 16'sh0000);
    repeat (256) step(1'b1, 16'sh0000);
    reset_all();
    idle(3);
    chk("rmid_state", 32'(st_m), S_ADAPT);
    chk("rmid_conv_time", 32'(ct_m), 0);
    chk("rmid_pwr", 32'(pwr_m), 0);
    repeat (255) step(1'b1, 16'sh0000);
    idle(3);
    chk("rmid_not_yet", 32'(conv_m), 0);
    step(1'b1, 16'sh0000);
    idle(3);
    chk("rmid_converged", 32'(conv_m), 1);
    chk("rmid_conv_time", 32'(ct_m), 256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
